arbiter_4way_rr: RTL and testbench

// - Round-robin arbiter sharing one WIDTH-bit resource port (memory write port, output latch) among 4 requesters.
// - Produces a registered one-hot grant plus 2-bit select, so the grant can drive the 4-way demux/mux select path.
// - Forwards the owner's data word to the shared resource.
// - Sequences ownership changes through a one-cycle bus turnaround gap.

---
 rtl/arbiter_4way_rr_if.sv | 31 +++
 rtl/arbiter_4way_rr.sv | 116 +++++++++++
 tb/tb_arbiter_4way_rr.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/arbiter_4way_rr_if.sv
// Bundle between the four requesters and the round-robin arbiter.
// The requester side drives req/din. The arbiter side returns the grant,
// the owner index, and the forwarded data word.
interface arbiter_4way_rr_if #(
    parameter int WIDTH = 16
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] din;
    logic [3:0]         gnt;
    logic [1:0]         gnt_sel;
    logic               gnt_valid;
    logic [WIDTH-1:0]   dout;

    modport master (
        output req,
        output din,
        input  gnt,
        input  gnt_sel,
        input  gnt_valid,
        input  dout
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output gnt_sel,
        output gnt_valid,
        output dout
    );
endinterface

// File: rtl/arbiter_4way_rr.sv
// Four-way round-robin arbiter for one shared WIDTH-bit resource port.
// The grant is registered and one-hot. Every change of owner passes through
// a single turnaround cycle in which no grant is active. An owner can be
// forced off after MAX_HOLD cycles while someone else waits.
module arbiter_4way_rr #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 16
) (
    input logic              clk,
    input logic              rst,
    arbiter_4way_rr_if.slave bus
);
    localparam int HCNT_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int HOLD_LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(HOLD_LIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        ptr, ptr_nxt;
    logic [HCNT_W-1:0] hcnt, hcnt_nxt;
    logic [3:0]        gnt, gnt_nxt;
    logic [1:0]        sel, sel_nxt;

    logic              win_found;
    logic [1:0]        win_idx;
    logic              drop;
    logic              timeout;
    logic              gnt_valid;
    logic [WIDTH-1:0]  words [4];

    // Scan for the first requester, starting at ptr and wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        for (int k = 0; k < 4; k++) begin
            if (!win_found && bus.req[ptr + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = ptr + 2'(k);
            end
        end
    end

    // Release causes while BUSY. sel names the owner in that state.
    // The hold limit only applies when another requester is waiting.
    assign drop    = ~bus.req[sel];
    assign timeout = (MAX_HOLD != 0) && (hcnt == HCNT_MAX) && ((bus.req & ~gnt) != 4'b0000);

    // Next-state and next-grant logic. Arbitration runs in both IDLE and GAP.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hcnt_nxt  = hcnt;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        case (state)
            IDLE, GAP: begin
                if (win_found) begin
                    state_nxt = BUSY;
                    gnt_nxt   = 4'b0001 << win_idx;
                    sel_nxt   = win_idx;
                    hcnt_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                end
            end
            BUSY: begin
                if (drop || timeout) begin
                    // The released owner drops to lowest priority for the next scan.
                    state_nxt = GAP;
                    gnt_nxt   = 4'b0000;
                    ptr_nxt   = sel + 2'd1;
                end else if ((MAX_HOLD != 0) && (hcnt != HCNT_MAX)) begin
                    hcnt_nxt = hcnt + HCNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    // State, pointer, hold counter and grant registers. Reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            hcnt  <= '0;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            hcnt  <= hcnt_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
        end
    end

    // Split the packed request bus into words so the owner can select one.
    for (genvar i = 0; i < 4; i++) begin : g_words
        assign words[i] = bus.din[i*WIDTH +: WIDTH];
    end

    assign gnt_valid     = |gnt;
    assign bus.gnt       = gnt;
    assign bus.gnt_sel   = sel;
    assign bus.gnt_valid = gnt_valid;
    assign bus.dout      = gnt_valid ? words[sel] : '0;
endmodule

// File: tb/tb_arbiter_4way_rr.sv
// Bench for arbiter_4way_rr.
// Tracks owner, pointer and hold time as plain integers, checks every cycle,
// and adds directed scenarios with literal expected values.
module tb_arbiter_4way_rr;
    localparam int W  = 16;
    localparam int MH = 4;
    localparam logic [63:0] DIN_FIX = {16'hD003, 16'hC002, 16'hA001, 16'hBEEF};

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   cmp_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    arbiter_4way_rr_if #(.WIDTH(W)) bus ();

    arbiter_4way_rr #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = none), last owner, priority start, cycles held.
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_held  = 0;

    always @(posedge clk or posedge rst) begin
        int nown, nlast, nptr, nheld;
        logic [3:0] r;
        if (rst) begin
            m_owner <= -1;
            m_last  <= 0;
            m_ptr   <= 0;
            m_held  <= 0;
        end else begin
            r     = bus.req;
            nown  = m_owner;
            nlast = m_last;
            nptr  = m_ptr;
            nheld = m_held;
            if (m_owner >= 0) begin
                nheld = m_held + 1;
                if (!r[m_owner] ||
                    (MH != 0 && nheld >= MH && (r & ~(4'b0001 << m_owner)) != 4'b0000)) begin
                    nown = -1;
                    nptr = (m_owner + 1) % 4;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (nown < 0 && r[(m_ptr + k) % 4]) begin
                        nown  = (m_ptr + k) % 4;
                        nlast = nown;
                        nheld = 0;
                    end
                end
            end
            m_owner <= nown;
            m_last  <= nlast;
            m_ptr   <= nptr;
            m_held  <= nheld;
        end
    end

    // Compare the DUT against the model on every cycle.
    always @(posedge clk) begin
        logic [3:0]   e_gnt;
        logic [W-1:0] e_dout;
        #1;
        if (cmp_en) begin
            e_gnt  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            e_dout = (m_owner >= 0) ? bus.din[m_owner*W +: W] : '0;
            chk("model_gnt",       32'(bus.gnt),       32'(e_gnt));
            chk("model_gnt_sel",   32'(bus.gnt_sel),   32'(m_last));
            chk("model_gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
            chk("model_dout",      32'(bus.dout),      32'(e_dout));
        end
    end

    task automatic cyc_check(input string name, input logic [3:0] g);
        @(posedge clk);
        #1;
        chk(name, 32'(bus.gnt), 32'(g));
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] mask;
        bus.req = 4'b0000;
        bus.din = DIN_FIX;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("idle_gnt",   32'(bus.gnt),       32'h0);
            chk("idle_valid", 32'(bus.gnt_valid), 32'h0);
            chk("idle_dout",  32'(bus.dout),      32'h0);
        end

        // Single requester 0
        @(negedge clk);
        bus.req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            cyc_check("single_gnt", 4'b0001);
            chk("single_dout", 32'(bus.dout), 32'hBEEF);
        end
        @(negedge clk);
        bus.req = 4'b0000;
        cyc_check("single_release", 4'b0000);
        chk("single_sel_kept", 32'(bus.gnt_sel), 32'h0);

        // All request; each owner drops for one cycle after its grant
        do_reset();
        @(negedge clk);
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            cyc_check("rr_grant", 4'b0001 << (g % 4));
            chk("rr_sel", 32'(bus.gnt_sel), 32'(g % 4));
            @(negedge clk);
            bus.req = 4'b1111 & ~(4'b0001 << (g % 4));
            cyc_check("rr_gap", 4'b0000);
            @(negedge clk);
            bus.req = 4'b1111;
        end
        @(negedge clk);
        bus.req = 4'b0000;

        // Hold limit: owner 2 is forced off after 4 cycles while 3 waits
        do_reset();
        @(negedge clk);
        bus.req = 4'b0100;
        cyc_check("hold_gnt", 4'b0100);
        @(negedge clk);
        bus.req = 4'b1100;
        for (int i = 0; i < 3; i++) begin
            cyc_check("hold_gnt", 4'b0100);
            chk("hold_dout", 32'(bus.dout), 32'hC002);
        end
        cyc_check("hold_gap", 4'b0000);
        cyc_check("hold_next", 4'b1000);
        @(negedge clk);
        bus.req = 4'b0000;

        // Pointer at 2 after owner 1 releases; requesters 0 and 1 -> 0 wins
        do_reset();
        @(negedge clk);
        bus.req = 4'b0010;
        cyc_check("ptr_gnt1", 4'b0010);
        @(negedge clk);
        bus.req = 4'b0001;
        cyc_check("ptr_gap", 4'b0000);
        @(negedge clk);
        bus.req = 4'b0011;
        cyc_check("ptr_wrap_win0", 4'b0001);
        chk("ptr_wrap_dout", 32'(bus.dout), 32'hBEEF);
        @(negedge clk);
        bus.req = 4'b0000;

        // Asynchronous reset in the middle of a grant to owner 3 (pointer at 3)
        do_reset();
        @(negedge clk);
        bus.req = 4'b0100;
        cyc_check("arst_gnt2", 4'b0100);
        @(negedge clk);
        bus.req = 4'b0000;
        cyc_check("arst_gap", 4'b0000);
        @(negedge clk);
        bus.req = 4'b1000;
        cyc_check("arst_gnt3", 4'b1000);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gnt",   32'(bus.gnt),       32'h0);
        chk("arst_valid", 32'(bus.gnt_valid), 32'h0);
        chk("arst_sel",   32'(bus.gnt_sel),   32'h0);
        chk("arst_dout",  32'(bus.dout),      32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1010;
        cyc_check("arst_ptr0", 4'b0010);
        @(negedge clk);
        bus.req = 4'b0000;

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(199) == 0);
            mask = 4'b0000;
            for (int b = 0; b < 4; b++) begin
                mask[b] = ($urandom_range(3) == 0);
            end
            bus.req = bus.req ^ mask;
            bus.din = {$urandom, $urandom};
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
